// File: rtl/config_chain_loader.sv
// Serializes valid/ready bitstream words LSB-first onto a tile configuration chain.
// Optional CRC-8 trailer check is compiled in with CONFIG_LOADER_CRC_EN.
module config_chain_loader #(
    parameter int WORD_WIDTH   = 8,
    parameter int CHAIN_LENGTH = 96,
    parameter int COUNT_WIDTH  = 16
) (
    input  logic                  clock,
    input  logic                  nreset,
    input  logic                  start,
    input  logic                  abort,
    input  logic [WORD_WIDTH-1:0] word_in,
    input  logic                  word_valid,
    output logic                  word_ready,
    output logic                  config_out,
    output logic                  config_enable,
    output logic                  busy,
    output logic                  done,
    output logic                  crc_error
);

    localparam int WB_WIDTH = $clog2(WORD_WIDTH + 1);
    localparam logic [COUNT_WIDTH-1:0] LP_CHAIN = COUNT_WIDTH'(CHAIN_LENGTH);
    localparam logic [COUNT_WIDTH-1:0] LP_WORD  = COUNT_WIDTH'(WORD_WIDTH);

`ifdef CONFIG_LOADER_CRC_EN
    typedef enum logic [2:0] {ST_IDLE, ST_FETCH, ST_SHIFT, ST_CHECK, ST_DONE} state_t;
`else
    typedef enum logic [2:0] {ST_IDLE, ST_FETCH, ST_SHIFT, ST_DONE} state_t;
`endif

    state_t                  r_state;
    state_t                  w_next;
    logic [WORD_WIDTH-1:0]   r_shift;
    logic [COUNT_WIDTH-1:0]  r_bit_count;
    logic [WB_WIDTH-1:0]     r_word_bits;
    logic                    w_accept;
    logic                    w_shift;
    logic                    w_clear;
    logic                    w_last_bit;
    logic [COUNT_WIDTH-1:0]  w_remaining;
    logic [WB_WIDTH-1:0]     w_load_bits;
`ifdef CONFIG_LOADER_CRC_EN
    logic                    w_trailer;
    logic                    w_fb;
    logic [7:0]              r_crc;
    logic                    r_crc_error;
`endif

    // The final word may be only partly used; its upper bits are never shifted.
    assign w_remaining = LP_CHAIN - r_bit_count;
    assign w_load_bits = (w_remaining < LP_WORD) ? WB_WIDTH'(w_remaining)
                                                 : WB_WIDTH'(WORD_WIDTH);
    assign w_last_bit  = (r_bit_count + COUNT_WIDTH'(1)) == LP_CHAIN;
    assign config_out  = config_enable & r_shift[0];

    always_ff @(posedge clock or negedge nreset) begin
        if (!nreset) begin
            r_state <= ST_IDLE;
        end else begin
            r_state <= w_next;
        end
    end

    always_comb begin
        w_next        = r_state;
        word_ready    = 1'b0;
        config_enable = 1'b0;
        busy          = 1'b0;
        done          = 1'b0;
        w_accept      = 1'b0;
        w_shift       = 1'b0;
        w_clear       = 1'b0;
`ifdef CONFIG_LOADER_CRC_EN
        w_trailer     = 1'b0;
`endif
        case (r_state)
            ST_IDLE: begin
                if (start) begin
                    w_next  = ST_FETCH;
                    w_clear = 1'b1;
                end
            end
            ST_FETCH: begin
                busy       = 1'b1;
                word_ready = 1'b1;
                if (word_valid) begin
                    w_accept = 1'b1;
                    w_next   = ST_SHIFT;
                end
            end
            ST_SHIFT: begin
                busy          = 1'b1;
                config_enable = 1'b1;
                w_shift       = 1'b1;
                if (r_word_bits == WB_WIDTH'(1)) begin
`ifdef CONFIG_LOADER_CRC_EN
                    w_next = w_last_bit ? ST_CHECK : ST_FETCH;
`else
                    w_next = w_last_bit ? ST_DONE : ST_FETCH;
`endif
                end
            end
`ifdef CONFIG_LOADER_CRC_EN
            ST_CHECK: begin
                busy       = 1'b1;
                word_ready = 1'b1;
                if (word_valid) begin
                    w_trailer = 1'b1;
                    w_next    = ST_DONE;
                end
            end
`endif
            ST_DONE: begin
                done = 1'b1;
                if (start) begin
                    w_next  = ST_FETCH;
                    w_clear = 1'b1;
                end
            end
            default: w_next = ST_IDLE;
        endcase
        if (abort) begin
            w_next = ST_IDLE;
        end
    end

    always_ff @(posedge clock or negedge nreset) begin
        if (!nreset) begin
            r_shift     <= '0;
            r_bit_count <= '0;
            r_word_bits <= '0;
        end else begin
            if (w_clear) begin
                r_bit_count <= '0;
            end
            if (w_accept) begin
                r_shift     <= word_in;
                r_word_bits <= w_load_bits;
            end else if (w_shift) begin
                r_shift     <= r_shift >> 1;
                r_bit_count <= r_bit_count + COUNT_WIDTH'(1);
                r_word_bits <= r_word_bits - WB_WIDTH'(1);
            end
        end
    end

`ifdef CONFIG_LOADER_CRC_EN
    // MSB-first CRC-8, polynomial 0x07, fed with each bit as it leaves on config_out.
    assign w_fb = r_crc[7] ^ r_shift[0];

    always_ff @(posedge clock or negedge nreset) begin
        if (!nreset) begin
            r_crc       <= '0;
            r_crc_error <= 1'b0;
        end else if (w_clear || abort) begin
            r_crc       <= '0;
            r_crc_error <= 1'b0;
        end else begin
            if (w_shift) begin
                r_crc <= {r_crc[6:0], 1'b0} ^ (w_fb ? 8'h07 : 8'h00);
            end
            if (w_trailer) begin
                r_crc_error <= (word_in[7:0] != r_crc);
            end
        end
    end

    assign crc_error = r_crc_error;
`else
    assign crc_error = 1'b0;
`endif

endmodule

// File: tb/tb_config_chain_loader.sv
// Directed bench for config_chain_loader (WORD_WIDTH=8, CHAIN_LENGTH=18).
// Define CONFIG_LOADER_CRC_EN to also cover the CRC trailer path.
module tb_config_chain_loader;

    localparam logic [17:0] EXP_BITS = 18'h23CA5;  // A5, 3C, then low two bits of 02

    logic       clock = 1'b0;
    logic       nreset;
    logic       start;
    logic       abort;
    logic [7:0] word_in;
    logic       word_valid;
    logic       word_ready;
    logic       config_out;
    logic       config_enable;
    logic       busy;
    logic       done;
    logic       crc_error;

    int total = 0;
    int bad   = 0;

    logic mon_bit [0:1023];
    int   mon_cnt  = 0;
    int   stab_bad = 0;

    typedef struct {
        logic       s;
        logic       v;
        logic [7:0] w;
        logic [4:0] exp;  // {word_ready, config_enable, config_out, busy, done}
    } vec_t;

    vec_t tbl [21];

    config_chain_loader #(
        .WORD_WIDTH  (8),
        .CHAIN_LENGTH(18),
        .COUNT_WIDTH (16)
    ) dut (
        .clock        (clock),
        .nreset       (nreset),
        .start        (start),
        .abort        (abort),
        .word_in      (word_in),
        .word_valid   (word_valid),
        .word_ready   (word_ready),
        .config_out   (config_out),
        .config_enable(config_enable),
        .busy         (busy),
        .done         (done),
        .crc_error    (crc_error)
    );

    always #5 clock = ~clock;

    always @(posedge clock) begin
        #1;
        if (config_enable) begin
            if (mon_cnt < 1024) mon_bit[mon_cnt] = config_out;
            mon_cnt++;
        end else if (config_out) begin
            stab_bad++;
        end
    end

    initial begin
        #1000000;
        $display("FAIL watchdog: simulation did not finish, bad=%0d", bad);
        $fatal(1, "watchdog");
    end

    task automatic tick;
        @(posedge clock);
        #2;
    endtask

    task automatic chk(input string nm, input logic [31:0] got, input logic [31:0] exp);
        total++;
        if (got !== exp) begin
            bad++;
            $display("FAIL %s got=%h exp=%h", nm, got, exp);
        end
    endtask

    function automatic logic [17:0] get_bits(input int base);
        logic [17:0] r;
        r = '0;
        for (int i = 0; i < 18; i++) r[i] = mon_bit[base + i];
        return r;
    endfunction

    function automatic logic [7:0] crc8(input logic [17:0] bits);
        logic [7:0] c;
        logic       fb;
        c = 8'h00;
        for (int i = 0; i < 18; i++) begin
            fb = c[7] ^ bits[i];
            c  = {c[6:0], 1'b0};
            if (fb) c = c ^ 8'h07;
        end
        return c;
    endfunction

    task automatic do_start;
        start = 1'b1;
        tick();
        start = 1'b0;
    endtask

    task automatic drive_word(input logic [7:0] w, input int gap);
        int n = 0;
        while (!word_ready && n < 40) begin
            tick();
            n++;
        end
        if (!word_ready) chk("fetch_timeout", 32'(word_ready), 32'd1);
        for (int g = 0; g < gap; g++) begin
            word_valid = 1'b0;
            tick();
            chk("stall_ready_enable", {word_ready, config_enable}, 2'b10);
        end
        word_valid = 1'b1;
        word_in    = w;
        tick();
        word_valid = 1'b0;
        word_in    = 8'h00;
    endtask

    task automatic finish_load(input logic [7:0] xr);
        int n = 0;
`ifdef CONFIG_LOADER_CRC_EN
        while (!word_ready && n < 40) begin
            tick();
            n++;
        end
        if (!word_ready) chk("check_timeout", 32'(word_ready), 32'd1);
        chk("check_enable_low", 32'(config_enable), 32'd0);
        word_valid = 1'b1;
        word_in    = crc8(EXP_BITS) ^ xr;
        tick();
        word_valid = 1'b0;
        word_in    = 8'h00;
        chk("crc_error", 32'(crc_error), 32'(xr != 8'h00));
`else
        while (!done && n < 40) begin
            tick();
            n++;
        end
`endif
        chk("done_state", {word_ready, config_enable, busy, done}, 4'b0001);
    endtask

    task automatic load_three(input int gap2);
        do_start();
        drive_word(8'hA5, 0);
        drive_word(8'h3C, gap2);
        drive_word(8'h02, 0);
    endtask

    initial begin
        int base;

        tbl[0]  = '{1'b1, 1'b1, 8'hA5, 5'b10010};
        tbl[1]  = '{1'b0, 1'b1, 8'hA5, 5'b01110};
        tbl[2]  = '{1'b0, 1'b0, 8'h00, 5'b01010};
        tbl[3]  = '{1'b0, 1'b0, 8'h00, 5'b01110};
        tbl[4]  = '{1'b0, 1'b0, 8'h00, 5'b01010};
        tbl[5]  = '{1'b0, 1'b0, 8'h00, 5'b01010};
        tbl[6]  = '{1'b0, 1'b0, 8'h00, 5'b01110};
        tbl[7]  = '{1'b0, 1'b0, 8'h00, 5'b01010};
        tbl[8]  = '{1'b0, 1'b0, 8'h00, 5'b01110};
        tbl[9]  = '{1'b0, 1'b1, 8'h3C, 5'b10010};
        tbl[10] = '{1'b0, 1'b1, 8'h3C, 5'b01010};
        tbl[11] = '{1'b0, 1'b0, 8'h00, 5'b01010};
        tbl[12] = '{1'b0, 1'b0, 8'h00, 5'b01110};
        tbl[13] = '{1'b0, 1'b0, 8'h00, 5'b01110};
        tbl[14] = '{1'b0, 1'b0, 8'h00, 5'b01110};
        tbl[15] = '{1'b0, 1'b0, 8'h00, 5'b01110};
        tbl[16] = '{1'b0, 1'b0, 8'h00, 5'b01010};
        tbl[17] = '{1'b0, 1'b0, 8'h00, 5'b01010};
        tbl[18] = '{1'b0, 1'b1, 8'h02, 5'b10010};
        tbl[19] = '{1'b0, 1'b1, 8'h02, 5'b01010};
        tbl[20] = '{1'b0, 1'b0, 8'h00, 5'b01110};

        nreset     = 1'b0;
        start      = 1'b0;
        abort      = 1'b0;
        word_in    = 8'h00;
        word_valid = 1'b0;
        repeat (3) tick();
        chk("reset_outputs", {word_ready, config_out, config_enable, busy, done, crc_error}, 6'b0);
        nreset = 1'b1;
        tick();

        // Basic load, cycle by cycle
        base = mon_cnt;
        for (int i = 0; i < 21; i++) begin
            start      = tbl[i].s;
            word_valid = tbl[i].v;
            word_in    = tbl[i].w;
            tick();
            chk($sformatf("vec%0d", i), {word_ready, config_enable, config_out, busy, done}, tbl[i].exp);
        end
        start      = 1'b0;
        word_valid = 1'b0;
        word_in    = 8'h00;
        finish_load(8'h00);
        chk("basic_bits", get_bits(base), EXP_BITS);
        chk("basic_count", mon_cnt - base, 18);

        // Backpressure before the second word
        base = mon_cnt;
        load_three(5);
        finish_load(8'h00);
        chk("bp_bits", get_bits(base), EXP_BITS);
        chk("bp_count", mon_cnt - base, 18);

        // Abort after 7 bits, then a full reload
        base = mon_cnt;
        do_start();
        drive_word(8'hA5, 0);
        repeat (6) tick();
        chk("abort_bits_before", mon_cnt - base, 7);
        abort = 1'b1;
        tick();
        abort = 1'b0;
        chk("abort_outputs", {config_enable, config_out, busy, done, word_ready}, 5'b0);
        repeat (3) tick();
        chk("abort_no_done", {done, busy}, 2'b00);
        base = mon_cnt;
        load_three(0);
        finish_load(8'h00);
        chk("reload_bits", get_bits(base), EXP_BITS);
        chk("reload_count", mon_cnt - base, 18);

        // Start pulses while shifting are ignored
        base = mon_cnt;
        do_start();
        drive_word(8'hA5, 0);
        start = 1'b1;
        repeat (3) tick();
        chk("start_in_shift", {busy, config_enable, done}, 3'b110);
        start = 1'b0;
        drive_word(8'h3C, 0);
        drive_word(8'h02, 0);
        finish_load(8'h00);
        chk("ignstart_bits", get_bits(base), EXP_BITS);
        chk("ignstart_count", mon_cnt - base, 18);

        // Asynchronous reset mid-SHIFT
        do_start();
        drive_word(8'hA5, 0);
        tick();
        nreset = 1'b0;
        #1;
        chk("async_reset", {word_ready, config_out, config_enable, busy, done, crc_error}, 6'b0);
        tick();
        nreset = 1'b1;
        tick();
        chk("after_reset_idle", {word_ready, config_enable, busy, done}, 4'b0);

        // Excess word after done is not consumed until a new start
        base = mon_cnt;
        load_three(0);
        finish_load(8'h00);
        word_valid = 1'b1;
        word_in    = 8'hFF;
        repeat (5) tick();
        chk("excess_held", {word_ready, busy, done}, 3'b001);
        chk("excess_count", mon_cnt - base, 18);
        start = 1'b1;
        tick();
        start = 1'b0;
        chk("restart_fetch", {word_ready, busy, done}, 3'b110);
        tick();
        chk("restart_consume", {config_enable, config_out}, 2'b11);
        word_valid = 1'b0;
        word_in    = 8'h00;
        abort = 1'b1;
        tick();
        abort = 1'b0;

`ifdef CONFIG_LOADER_CRC_EN
        // Corrupted trailer flags an error; start clears it
        load_three(0);
        finish_load(8'h01);
        chk("crc_err_done", {done, crc_error}, 2'b11);
        do_start();
        chk("crc_err_clear", 32'(crc_error), 32'd0);
        abort = 1'b1;
        tick();
        abort = 1'b0;
`endif

        chk("chain_stability", stab_bad, 0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
